gb_cpu_uop_scheduler: RTL

GB_CPU_UOP_SCHEDULER -- requirements
Module: gb_cpu_uop_scheduler

---
 rtl/gb_cpu_uop_scheduler.sv | 99 +++++++++
 1 files changed

// File: rtl/gb_cpu_uop_scheduler.sv
// Per-instruction micro-op queue: holds up to DEPTH per-M-cycle control entries,
// presents the head entry each M-cycle and supports overlapped fetch and early exit.
module gb_cpu_uop_scheduler #(
  parameter int DEPTH   = 6,
  parameter int ENTRY_W = 64,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  input  logic                     load,
  input  logic [DEPTH*ENTRY_W-1:0] load_entries,
  input  logic [CNT_W-1:0]         load_len,
  input  logic                     truncate,
  input  logic [CNT_W-1:0]         truncate_len,
  output logic [ENTRY_W-1:0]       cur_entry,
  output logic                     cur_valid,
  output logic                     last,
  output logic [CNT_W-1:0]         remaining,
  output logic                     load_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [ENTRY_W-1:0] slots_q [DEPTH];
  logic [ENTRY_W-1:0] slots_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               load_err_q, load_err_d;

  logic [CNT_W-1:0]   load_n;
  logic [CNT_W-1:0]   count_dec;
  logic [CNT_W-1:0]   trunc_n;
  logic               adv_ok;

  assign load_n    = (load_len > DEPTH_C) ? DEPTH_C : load_len;
  assign count_dec = count_q - ONE_C;
  assign trunc_n   = (truncate_len < count_dec) ? truncate_len : count_dec;
  assign adv_ok    = advance && (count_q != '0);

  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = load_n;
      // Overwriting entries that never executed means the decoder lost an instruction tail.
      load_err_d = (load_len > DEPTH_C) || (count_q > ONE_C) ||
                   ((count_q == ONE_C) && !advance);
    end else if (adv_ok) begin
      count_d = truncate ? trunc_n : count_dec;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
    logic [ENTRY_W-1:0] shifted;

    if (gi < DEPTH - 1) begin : g_shift
      assign shifted = slots_q[gi+1];
    end else begin : g_top
      assign shifted = '0;
    end

    always_comb begin
      slots_d[gi] = slots_q[gi];
      if (load) begin
        slots_d[gi] = (IDX < load_n) ? load_entries[gi*ENTRY_W +: ENTRY_W] : '0;
      end else if (adv_ok) begin
        slots_d[gi] = (truncate && (IDX >= trunc_n)) ? '0 : shifted;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slots_q[gi] <= '0;
      end else begin
        slots_q[gi] <= slots_d[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  // Empty queue presents the all-zero NOP entry.
  assign cur_entry = (count_q != '0) ? slots_q[0] : '0;
  assign cur_valid = (count_q != '0);
  assign last      = (count_q == ONE_C);
  assign remaining = count_q;
  assign load_err  = load_err_q;

endmodule
